btn_event_sched: RTL and testbench

Per-button event controller and round-robin scheduler placed after the bank of `debouncer` instances in the fitness-timer front end. It tracks up to `N_BTN` debounced button levels and classifies their activity into press, long-press, auto-repeat and release events. It then serialises those events onto one valid/ready stream that the timer control FSM consumes. Hold-time measurement counts an external `tick` strobe, so thresholds are independent of `clk` frequency.

---
 rtl/btn_event_sched.sv | 189 ++++++++++++++++++
 tb/tb_btn_event_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_sched.sv
// Per-button press/long/repeat/release classifier with a one-entry pending slot per
// button, serialised onto a single valid/ready event stream by a round-robin arbiter.
module btn_event_sched #(
    parameter int unsigned N_BTN        = 4,
    parameter int unsigned LONG_TICKS   = 8,
    parameter int unsigned REPEAT_TICKS = 4,
    parameter int unsigned CW           = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tick,
    input  logic [N_BTN-1:0]         btn_lvl,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic [1:0]               evt_type,
    output logic [N_BTN-1:0]         overflow,
    input  logic                     clr_overflow
);

    localparam int unsigned IW = $clog2(N_BTN);

    localparam logic [1:0] EVT_REL   = 2'b00;
    localparam logic [1:0] EVT_PRESS = 2'b01;
    localparam logic [1:0] EVT_LONG  = 2'b10;
    localparam logic [1:0] EVT_REP   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_HELD    = 2'd2
    } state_t;

    state_t            r_state [N_BTN];
    logic [CW-1:0]     r_cnt   [N_BTN];
    logic [1:0]        r_ptype [N_BTN];
    logic [N_BTN-1:0]  r_prev;
    logic [N_BTN-1:0]  r_pend;
    logic [N_BTN-1:0]  r_overflow;
    logic [IW-1:0]     r_rr_ptr;
    logic              r_evt_valid;
    logic [IW-1:0]     r_evt_id;
    logic [1:0]        r_evt_type;

    logic [N_BTN-1:0]  w_rise;
    logic [N_BTN-1:0]  w_fall;
    logic [N_BTN-1:0]  w_emit;
    logic [1:0]        w_etype   [N_BTN];
    logic [CW-1:0]     w_cnt_inc [N_BTN];
    logic              w_load;
    logic              w_any;
    logic [IW-1:0]     w_win;
    int unsigned       w_idx;
    logic [N_BTN-1:0]  w_grant;
    logic [IW-1:0]     w_rr_next;

    assign w_rise = btn_lvl & ~r_prev;
    assign w_fall = ~btn_lvl & r_prev;

    // Event classification; a falling edge masks any tick-driven event in the same cycle
    always_comb begin
        for (int i = 0; i < int'(N_BTN); i++) begin
            w_emit[i]    = 1'b0;
            w_etype[i]   = EVT_REL;
            w_cnt_inc[i] = r_cnt[i] + CW'(1);
            case (r_state[i])
                S_IDLE: begin
                    if (w_rise[i]) begin
                        w_emit[i]  = 1'b1;
                        w_etype[i] = EVT_PRESS;
                    end
                end
                S_PRESSED: begin
                    if (w_fall[i]) begin
                        w_emit[i] = 1'b1;
                    end else if (tick && (w_cnt_inc[i] == CW'(LONG_TICKS))) begin
                        w_emit[i]  = 1'b1;
                        w_etype[i] = EVT_LONG;
                    end
                end
                S_HELD: begin
                    if (w_fall[i]) begin
                        w_emit[i] = 1'b1;
                    end else if (tick && (w_cnt_inc[i] == CW'(REPEAT_TICKS))) begin
                        w_emit[i]  = 1'b1;
                        w_etype[i] = EVT_REP;
                    end
                end
                default: ;
            endcase
        end
    end

    // Round-robin search over pending slots starting at r_rr_ptr
    always_comb begin
        w_load = ~r_evt_valid | evt_ready;
        w_any  = 1'b0;
        w_win  = '0;
        w_idx  = 0;
        for (int unsigned k = 0; k < N_BTN; k++) begin
            w_idx = 32'(r_rr_ptr) + k;
            if (w_idx >= N_BTN) begin
                w_idx = w_idx - N_BTN;
            end
            if (!w_any && r_pend[IW'(w_idx)]) begin
                w_any = 1'b1;
                w_win = IW'(w_idx);
            end
        end
        for (int i = 0; i < int'(N_BTN); i++) begin
            w_grant[i] = w_load & w_any & (w_win == IW'(i));
        end
        w_rr_next = (w_win == IW'(N_BTN - 1)) ? '0 : w_win + IW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_BTN); i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
                r_ptype[i] <= EVT_REL;
            end
            r_prev      <= '0;
            r_pend      <= '0;
            r_overflow  <= '0;
            r_rr_ptr    <= '0;
            r_evt_valid <= 1'b0;
            r_evt_id    <= '0;
            r_evt_type  <= EVT_REL;
        end else begin
            r_prev <= btn_lvl;
            for (int i = 0; i < int'(N_BTN); i++) begin
                case (r_state[i])
                    S_IDLE: begin
                        if (w_rise[i]) begin
                            r_state[i] <= S_PRESSED;
                            r_cnt[i]   <= '0;
                        end
                    end
                    S_PRESSED: begin
                        if (w_fall[i]) begin
                            r_state[i] <= S_IDLE;
                        end else if (tick) begin
                            if (w_cnt_inc[i] == CW'(LONG_TICKS)) begin
                                r_state[i] <= S_HELD;
                                r_cnt[i]   <= '0;
                            end else begin
                                r_cnt[i] <= w_cnt_inc[i];
                            end
                        end
                    end
                    S_HELD: begin
                        if (w_fall[i]) begin
                            r_state[i] <= S_IDLE;
                        end else if (tick) begin
                            r_cnt[i] <= (w_cnt_inc[i] == CW'(REPEAT_TICKS)) ? '0 : w_cnt_inc[i];
                        end
                    end
                    default: r_state[i] <= S_IDLE;
                endcase

                // New event wins the slot even when it is granted this cycle
                if (w_emit[i]) begin
                    r_pend[i]  <= 1'b1;
                    r_ptype[i] <= w_etype[i];
                end else if (w_grant[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end

            r_overflow <= (r_overflow & ~{N_BTN{clr_overflow}}) | (w_emit & r_pend & ~w_grant);

            if (w_load) begin
                r_evt_valid <= w_any;
                if (w_any) begin
                    r_evt_id   <= w_win;
                    r_evt_type <= r_ptype[w_win];
                    r_rr_ptr   <= w_rr_next;
                end
            end
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_id    = r_evt_id;
    assign evt_type  = r_evt_type;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_btn_event_sched.sv
// Bench for btn_event_sched: directed scenarios plus random stimulus, every cycle
// compared against a hold-time based behavioural model.
module tb_btn_event_sched;

    localparam int unsigned N  = 4;
    localparam int unsigned LT = 8;
    localparam int unsigned RT = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b0;
    logic [N-1:0]  btn_lvl = '0;
    logic          evt_ready = 1'b0;
    logic          clr_overflow = 1'b0;
    logic          evt_valid;
    logic [IW-1:0] evt_id;
    logic [1:0]    evt_type;
    logic [N-1:0]  overflow;

    always #5 clk = ~clk;

    btn_event_sched #(
        .N_BTN(N), .LONG_TICKS(LT), .REPEAT_TICKS(RT), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn_lvl(btn_lvl),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_type(evt_type), .overflow(overflow), .clr_overflow(clr_overflow)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: hold duration in ticks since press decides long/repeat
    bit       m_valid;
    int       m_id, m_type, m_rr;
    bit [N-1:0] m_ovf;
    bit       m_prev [N];
    bit       m_held [N];
    bit       m_pend [N];
    int       m_ticks [N];
    int       m_ptype [N];

    int acc_id[$], acc_ty[$];
    int exp_id[$], exp_ty[$];

    function automatic void model_reset();
        m_valid = 0; m_id = 0; m_type = 0; m_rr = 0; m_ovf = '0;
        for (int i = 0; i < int'(N); i++) begin
            m_prev[i] = 0; m_held[i] = 0; m_pend[i] = 0; m_ticks[i] = 0; m_ptype[i] = 0;
        end
    endfunction

    function automatic void model_step();
        bit load, any, grant;
        int win;
        bit emit [N];
        int et [N];
        if (!rst_n) begin
            model_reset();
            return;
        end
        load = !m_valid || evt_ready;
        any = 0; win = 0;
        for (int k = 0; k < int'(N); k++) begin
            int j;
            j = (m_rr + k) % int'(N);
            if (!any && m_pend[j]) begin any = 1; win = j; end
        end
        for (int i = 0; i < int'(N); i++) begin
            bit rise, fall;
            rise = btn_lvl[i] && !m_prev[i];
            fall = !btn_lvl[i] && m_prev[i];
            emit[i] = 0; et[i] = 0;
            if (!m_held[i]) begin
                if (rise) begin emit[i] = 1; et[i] = 1; m_held[i] = 1; m_ticks[i] = 0; end
            end else if (fall) begin
                emit[i] = 1; et[i] = 0; m_held[i] = 0;
            end else if (tick) begin
                m_ticks[i]++;
                if (m_ticks[i] == int'(LT)) begin emit[i] = 1; et[i] = 2; end
                else if (m_ticks[i] > int'(LT) && ((m_ticks[i] - int'(LT)) % int'(RT)) == 0) begin
                    emit[i] = 1; et[i] = 3;
                end
            end
        end
        if (load) begin
            m_valid = any;
            if (any) begin
                m_id = win; m_type = m_ptype[win]; m_rr = (win + 1) % int'(N);
            end
        end
        if (clr_overflow) m_ovf = '0;
        for (int i = 0; i < int'(N); i++) begin
            grant = load && any && (win == i);
            if (emit[i]) begin
                if (m_pend[i] && !grant) m_ovf[i] = 1;
                m_pend[i] = 1; m_ptype[i] = et[i];
            end else if (grant) begin
                m_pend[i] = 0;
            end
            m_prev[i] = btn_lvl[i];
        end
    endfunction

    // One clock: drive inputs, log an accepted event, advance model, compare after the edge
    task automatic step(input bit [N-1:0] lvl, input bit tk, input bit rdy,
                        input bit clr = 0, input bit rn = 1);
        btn_lvl = lvl; tick = tk; evt_ready = rdy; clr_overflow = clr; rst_n = rn;
        if (rn && evt_valid && rdy) begin
            acc_id.push_back(int'(evt_id));
            acc_ty.push_back(int'(evt_type));
        end
        model_step();
        @(posedge clk);
        #1;
        chk("evt_valid", 32'(evt_valid), 32'(m_valid));
        if (m_valid) begin
            chk("evt_id", 32'(evt_id), 32'(m_id));
            chk("evt_type", 32'(evt_type), 32'(m_type));
        end
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic chk_acc(input string tag);
        chk({tag, "_count"}, 32'(acc_id.size()), 32'(exp_id.size()));
        for (int k = 0; k < exp_id.size(); k++) begin
            if (k < acc_id.size()) begin
                chk({tag, "_id"}, 32'(acc_id[k]), 32'(exp_id[k]));
                chk({tag, "_type"}, 32'(acc_ty[k]), 32'(exp_ty[k]));
            end
        end
        acc_id.delete(); acc_ty.delete(); exp_id.delete(); exp_ty.delete();
    endtask

    task automatic do_reset();
        step('0, 0, 1, 0, 0);
        step('0, 0, 1, 0, 0);
        step('0, 0, 1, 0, 1);
        acc_id.delete(); acc_ty.delete();
    endtask

    initial begin
        bit [N-1:0] cur;
        model_reset();
        #1;
        step('0, 0, 0, 0, 0);
        step('0, 0, 0, 0, 0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_id", 32'(evt_id), 32'd0);
        chk("rst_type", 32'(evt_type), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // Press latency
        for (int c = 0; c < 8; c++) step('0, 0, 1);
        step(4'b0010, 0, 1);
        chk("lat_t1_valid", 32'(evt_valid), 32'd0);
        step(4'b0010, 0, 1);
        chk("lat_t2_valid", 32'(evt_valid), 32'd1);
        chk("lat_t2_id", 32'(evt_id), 32'd1);
        chk("lat_t2_type", 32'(evt_type), 32'd1);
        step(4'b0010, 0, 1);
        chk("lat_t3_valid", 32'(evt_valid), 32'd0);

        // Long press and repeats
        do_reset();
        step(4'b0001, 0, 1);
        for (int t = 0; t < 16; t++) begin
            step(4'b0001, 1, 1);
            step(4'b0001, 0, 1);
        end
        step('0, 0, 1);
        for (int c = 0; c < 4; c++) step('0, 0, 1);
        exp_id = {0, 0, 0, 0, 0}; exp_ty = {1, 2, 3, 3, 0};
        chk_acc("long");

        // Simultaneous presses, round-robin from 0 then from 2
        do_reset();
        step(4'b1111, 0, 1);
        for (int c = 0; c < 6; c++) step(4'b1111, 0, 1);
        exp_id = {0, 1, 2, 3}; exp_ty = {1, 1, 1, 1};
        chk_acc("rr0");
        do_reset();
        step(4'b0010, 0, 1);
        for (int c = 0; c < 3; c++) step(4'b0010, 0, 1);
        step(4'b0000, 0, 1);
        for (int c = 0; c < 3; c++) step(4'b0000, 0, 1);
        acc_id.delete(); acc_ty.delete();
        step(4'b1111, 0, 1);
        for (int c = 0; c < 6; c++) step(4'b1111, 0, 1);
        exp_id = {2, 3, 0, 1}; exp_ty = {1, 1, 1, 1};
        chk_acc("rr2");

        // Stalled output holds steady, release waits in pending slot
        do_reset();
        step(4'b0100, 0, 0);
        for (int c = 0; c < 20; c++) step(4'b0100, 0, 0);
        chk("stall_valid", 32'(evt_valid), 32'd1);
        chk("stall_id", 32'(evt_id), 32'd2);
        chk("stall_type", 32'(evt_type), 32'd1);
        step(4'b0000, 0, 0);
        for (int c = 0; c < 3; c++) step(4'b0000, 0, 0);
        for (int c = 0; c < 4; c++) step(4'b0000, 0, 1);
        exp_id = {2, 2}; exp_ty = {1, 0};
        chk_acc("stall");

        // Press+release overwrite while stalled
        do_reset();
        step(4'b1000, 0, 0);
        step(4'b1000, 0, 0);
        step(4'b1010, 0, 0);
        step(4'b1010, 0, 0);
        step(4'b1000, 0, 0);
        chk("ovf_set", 32'(overflow), 32'b0010);
        for (int c = 0; c < 4; c++) step(4'b1000, 0, 1);
        exp_id = {3, 1}; exp_ty = {1, 0};
        chk_acc("ovf");
        step(4'b1000, 0, 1, 1);
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Asynchronous reset mid-hold with events in flight
        do_reset();
        step(4'b0001, 0, 0);
        for (int t = 0; t < int'(LT) + 2; t++) step(4'b0001, 1, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(evt_valid), 32'd0);
        acc_id.delete(); acc_ty.delete();
        step(4'b0001, 0, 1, 0, 0);
        step(4'b0001, 0, 1, 0, 0);
        for (int c = 0; c < 6; c++) step(4'b0001, 0, 1);
        exp_id = {0}; exp_ty = {1};
        chk_acc("post_rst");

        // Random traffic
        cur = 4'b0001;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < int'(N); i++)
                if ($urandom_range(15) == 0) cur[i] = ~cur[i];
            step(cur, $urandom_range(2) == 0, $urandom_range(3) != 0, $urandom_range(19) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
